// File: rtl/dec_stream.sv
// rtl/dec_stream.sv - two-stage streaming SECDED decoder for (8,4), (16,11) and (32,26) codewords
// Optional build macro DEC_ERR_POS_EN adds the err_pos output (index of the corrected bit).
module dec_stream #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int AMBA_WORD          = 32,
    parameter int CNT_WIDTH          = 16
) (
`ifdef DEC_ERR_POS_EN
    output logic [5:0]                    err_pos,
`endif
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    num_of_errors,
    input  logic                          clr_cnt,
    output logic [CNT_WIDTH-1:0]          corr_cnt,
    output logic [CNT_WIDTH-1:0]          uncorr_cnt
);
    localparam int MW = MAX_CODEWORD_WIDTH;

    function automatic int n_of(input logic [1:0] m);
        n_of = 8 << m;
    endfunction

    function automatic int pc_of(input logic [1:0] m);
        pc_of = 4 + int'(m);
    endfunction

    // Info bit i takes the i-th integer >= 3 that is not a power of two.
    function automatic logic [4:0] info_col(input int i);
        int n;
        info_col = '0;
        n = 0;
        for (int v = 3; v < 32; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (n == i) info_col = 5'(v);
                n++;
            end
        end
    endfunction

    function automatic logic [4:0] col_of(input int b, input int pc);
        if (b < pc - 1)       col_of = 5'(1 << b);
        else if (b == pc - 1) col_of = '0;
        else                  col_of = info_col(b - pc);
    endfunction

    function automatic logic [4:0] syndrome(input logic [MW-1:0] w, input int pc, input int n);
        syndrome = '0;
        for (int b = 0; b < MW; b++)
            if (b < n && w[b]) syndrome = syndrome ^ col_of(b, pc);
    endfunction

    // s == 0 with odd parity means the overall-parity bit itself flipped.
    function automatic logic [5:0] flip_pos(input logic [4:0] s, input int pc, input int n);
        flip_pos = 6'(pc - 1);
        for (int b = 0; b < MW; b++)
            if (b < n && b != pc - 1 && s != 0 && col_of(b, pc) == s) flip_pos = 6'(b);
    endfunction

    logic          v1_q, v1_d, par1_q, par1_d, ill1_q, ill1_d;
    logic [4:0]    syn1_q, syn1_d;
    logic [MW-1:0] word1_q, word1_d;
    logic [1:0]    mode1_q, mode1_d;
    logic          ov_q, ov_d;
    logic [MW-1:0] dout_q, dout_d;
    logic [1:0]    nerr_q, nerr_d;
    logic [CNT_WIDTH-1:0] corr_q, corr_d, uncorr_q, uncorr_d;
`ifdef DEC_ERR_POS_EN
    logic [5:0]    epos_q, epos_d;
`endif

    logic          advance, xfer, legal0;
    logic [1:0]    mode0, code2;
    logic [MW-1:0] mask0, word0, corr2, info2;
    logic [4:0]    syn0;
    logic [5:0]    pos2;

    always_comb begin
        mode0  = work_mod[1:0];
        legal0 = (work_mod[AMBA_WORD-1:2] == '0) && (mode0 != 2'd3) && (n_of(mode0) <= MW);
        for (int b = 0; b < MW; b++) mask0[b] = (b < n_of(mode0));
        word0 = data_in & mask0;
        case (mode0)
            2'd0:    syn0 = syndrome(word0, 4, 8);
            2'd1:    syn0 = syndrome(word0, 5, 16);
            default: syn0 = syndrome(word0, 6, 32);
        endcase
    end

    always_comb begin
        case (mode1_q)
            2'd0:    pos2 = flip_pos(syn1_q, 4, 8);
            2'd1:    pos2 = flip_pos(syn1_q, 5, 16);
            default: pos2 = flip_pos(syn1_q, 6, 32);
        endcase
        corr2 = par1_q ? (word1_q ^ (MW'(1) << pos2)) : word1_q;
        info2 = corr2 >> pc_of(mode1_q);
        if (ill1_q) begin
            info2 = '0;
            code2 = 2'd3;
        end else if (par1_q) begin
            code2 = 2'd1;
        end else if (syn1_q != '0) begin
            code2 = 2'd2;
        end else begin
            code2 = 2'd0;
        end
    end

    assign advance = !ov_q || out_ready;
    assign xfer    = ov_q && out_ready;

    always_comb begin
        v1_d = v1_q;  syn1_d = syn1_q;  par1_d = par1_q;  word1_d = word1_q;
        mode1_d = mode1_q;  ill1_d = ill1_q;
        ov_d = ov_q;  dout_d = dout_q;  nerr_d = nerr_q;
`ifdef DEC_ERR_POS_EN
        epos_d = epos_q;
`endif
        if (advance) begin
            v1_d = in_valid;
            if (in_valid) begin
                syn1_d  = syn0;
                par1_d  = ^word0;
                word1_d = word0;
                mode1_d = mode0;
                ill1_d  = !legal0;
            end
            ov_d = v1_q;
            if (v1_q) begin
                dout_d = info2;
                nerr_d = code2;
            end
`ifdef DEC_ERR_POS_EN
            epos_d = (v1_q && code2 == 2'd1) ? pos2 : 6'd0;
`endif
        end
    end

    // Clear wins over an increment landing in the same cycle.
    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (clr_cnt) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (xfer) begin
            if (nerr_q == 2'd1 && corr_q != '1)   corr_d   = corr_q + CNT_WIDTH'(1);
            if (nerr_q[1] && uncorr_q != '1)      uncorr_d = uncorr_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;  syn1_q <= '0;  par1_q <= 1'b0;  word1_q <= '0;
            mode1_q <= '0;  ill1_q <= 1'b0;
            ov_q <= 1'b0;  dout_q <= '0;  nerr_q <= '0;
            corr_q <= '0;  uncorr_q <= '0;
`ifdef DEC_ERR_POS_EN
            epos_q <= '0;
`endif
        end else begin
            v1_q <= v1_d;  syn1_q <= syn1_d;  par1_q <= par1_d;  word1_q <= word1_d;
            mode1_q <= mode1_d;  ill1_q <= ill1_d;
            ov_q <= ov_d;  dout_q <= dout_d;  nerr_q <= nerr_d;
            corr_q <= corr_d;  uncorr_q <= uncorr_d;
`ifdef DEC_ERR_POS_EN
            epos_q <= epos_d;
`endif
        end
    end

    assign in_ready      = advance;
    assign out_valid     = ov_q;
    assign data_out      = dout_q;
    assign num_of_errors = nerr_q;
    assign corr_cnt      = corr_q;
    assign uncorr_cnt    = uncorr_q;
`ifdef DEC_ERR_POS_EN
    assign err_pos       = epos_q;
`endif
endmodule
